min_row_sched: RTL and testbench
================================

MIN_ROW_SCHED -- requirements
Module: min_row_sched

Interface
REQ-001 SHALL have parameter LANES, 8, number of 16-bit lanes per row fed to the min unit.
REQ-002 SHALL have parameter DW, 16, lane data width in bits.
REQ-003 SHALL have parameter ADDR_W, 8, row-address width of the source memory.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_base in ADDR_W, and cmd_rows in ADDR_W+1; these form the job request: first row address and row count.
REQ-007 SHALL have ports mem_rd_en out 1, mem_rd_addr out ADDR_W, and mem_rd_data in LANES*DW; the row read port has 1-cycle read latency.
REQ-008 SHALL have ports fm_numbers out LANES*DW, fm_start out 1, fm_done in 1, and fm_result in DW; these drive the min-reduction unit.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_data out DW, out_row out ADDR_W, and out_last out 1; these carry per-row minimum results.
REQ-010 SHALL have port busy  out  1  high from command accept until the final result handshake.

Function
REQ-011 SHALL implement states IDLE, READ, LOAD, RUN, DRAIN, EMIT, plus ERR when MIN_SCHED_TIMEOUT_EN is defined.
REQ-012 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high; cmd_valid at any other time is ignored.
REQ-013 SHALL, on accept with cmd_rows=0, return to IDLE next cycle, emit no results, and keep busy low.
REQ-014 SHALL, on accept with cmd_rows>0, capture base/count, set row index=0, and enter READ.
REQ-015 SHALL pulse mem_rd_en for exactly one cycle in READ, with mem_rd_addr=(base+index) mod 2^ADDR_W (wrap-around), then enter LOAD.
REQ-016 SHALL, in LOAD, register mem_rd_data into fm_numbers (lane i = bits [i*DW+:DW]) and enter RUN.
REQ-017 SHALL hold fm_start high and fm_numbers stable for all of RUN, and SHALL ignore fm_done outside RUN.
REQ-018 SHALL, on fm_done=1 in RUN, capture fm_result into out_data, drop fm_start next cycle, and enter DRAIN.
REQ-019 SHALL keep fm_start low for exactly one cycle in DRAIN, so the min unit sees a start deassertion between rows, then enter EMIT.
REQ-020 SHALL hold out_valid high in EMIT with out_row=(base+index) mod 2^ADDR_W and out_last=(index==count-1); data, row and last SHALL stay stable while out_ready=0.
REQ-021 SHALL, on an out_valid/out_ready handshake, go to IDLE if out_last is set, else increment index and go to READ.
REQ-022 SHALL give minimum per-row latency from READ entry to out_valid of 4 cycles plus the min-unit latency; a blocked row SHALL not be prefetched.
REQ-023 SHALL pass lane values through unmodified; the scheduler performs no arithmetic on data.

Reset
REQ-024 SHALL, when rst=1 at a rising edge in any state (including mid-RUN), enter IDLE.
REQ-025 SHALL reset outputs as follows: cmd_ready=1 after reset; mem_rd_en=0, fm_start=0, out_valid=0, out_last=0, busy=0; fm_numbers, out_data, mem_rd_addr and out_row=0.

Configuration
REQ-026 SHALL, with MIN_SCHED_TIMEOUT_EN defined, count cycles in RUN; if 256 cycles pass without fm_done, it SHALL enter ERR, drive fm_start=0, hold busy=1, and leave ERR only on rst.
REQ-027 SHALL, without MIN_SCHED_TIMEOUT_EN, include no counter and no ERR state, and SHALL wait in RUN indefinitely.

Structure
REQ-028 SHALL place DW/LANES defaults and the state enum in shared package attn_pkg.
REQ-029 SHALL implement the timeout counter as sub-module min_sched_watchdog, instantiated only under MIN_SCHED_TIMEOUT_EN.
REQ-030 SHALL not instantiate the min unit internally; the min unit connects via the fm_* ports.

Verification
REQ-031 SHALL cover this case: base=0, rows=8, rows holding known minima, out_ready=1 -> 8 results in order, out_row 0..7, out_last only on row 7.
REQ-032 SHALL cover this case: rows=0 -> no mem_rd_en, no out_valid, and cmd_ready back high next cycle.
REQ-033 SHALL cover this case: base=8'hFE, rows=3 -> read addresses FE, FF, 00, with out_row matching.
REQ-034 SHALL cover this case: out_ready held low 10 cycles on row 2 -> out_data/out_row stable, and no mem_rd_en until the handshake.
REQ-035 SHALL cover this case: rst pulsed mid-RUN -> next cycle IDLE, fm_start=0, busy=0; a new command then completes normally.
REQ-036 SHALL cover this case: with MIN_SCHED_TIMEOUT_EN, fm_done stuck low -> ERR after 256 RUN cycles, fm_start=0, busy=1 until rst.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared definitions for the row-minimum scheduler: default lane geometry,
// watchdog limit and the scheduler state encoding.
// The ERR state exists only when MIN_SCHED_TIMEOUT_EN is defined.
package attn_pkg;

    localparam int DW_DEF    = 16;
    localparam int LANES_DEF = 8;
    localparam int WD_LIMIT  = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        EMIT  = 3'd5
`ifdef MIN_SCHED_TIMEOUT_EN
        ,
        ERR   = 3'd6
`endif
    } sched_state_e;

endpackage

// File: rtl/min_sched_watchdog.sv
// Watchdog for the RUN state of min_row_sched: counts consecutive RUN cycles
// without fm_done and flags expiry on the LIMIT-th such cycle.
// Built only when MIN_SCHED_TIMEOUT_EN is defined.
`ifdef MIN_SCHED_TIMEOUT_EN
module min_sched_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic done,
    output logic expired
);

    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Count RUN cycles that end without completion; any other cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (run && !done) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // The cycle that would be the LIMIT-th idle RUN cycle is the expiry point.
    assign expired = run && !done && (cnt_r == CNT_LAST);

endmodule
`endif

// File: rtl/min_row_sched.sv
// Row scheduler feeding an external min-reduction unit: reads one row per
// job step, presents it on fm_numbers, waits for fm_done and emits the row
// minimum with its row address. Optional RUN watchdog with a sticky ERR
// state is enabled by defining MIN_SCHED_TIMEOUT_EN.
module min_row_sched
    import attn_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DW     = DW_DEF,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_base,
    input  logic [ADDR_W:0]        cmd_rows,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic [LANES*DW-1:0]    mem_rd_data,
    output logic [LANES*DW-1:0]    fm_numbers,
    output logic                   fm_start,
    input  logic                   fm_done,
    input  logic [DW-1:0]          fm_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [ADDR_W-1:0]      out_row,
    output logic                   out_last,
    output logic                   busy
);

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    sched_state_e          state_r;
    sched_state_e          state_s;
    logic [ADDR_W-1:0]     row_addr_r;
    logic [ADDR_W:0]       idx_r;
    logic [ADDR_W:0]       cnt_r;
    logic                  cmd_ready_r;
    logic                  mem_rd_en_r;
    logic                  fm_start_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic                  busy_r;
    logic [LANES*DW-1:0]   fm_numbers_r;
    logic [DW-1:0]         out_data_r;
    logic                  rows_nz_s;
    logic                  last_s;

    assign rows_nz_s = (cmd_rows != {(ADDR_W+1){1'b0}});
    assign last_s    = (idx_r == (cnt_r - CNT_ONE));

`ifdef MIN_SCHED_TIMEOUT_EN
    logic wd_expired_s;
    logic wd_run_s;

    assign wd_run_s = (state_r == RUN);

    min_sched_watchdog #(
        .LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (wd_run_s),
        .done    (fm_done),
        .expired (wd_expired_s)
    );
`endif

    // Next-state logic of the row sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid && rows_nz_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:  state_s = LOAD;
            LOAD:  state_s = RUN;
            RUN: begin
                if (fm_done) begin
                    state_s = DRAIN;
                end
`ifdef MIN_SCHED_TIMEOUT_EN
                else if (wd_expired_s) begin
                    state_s = ERR;
                end
`endif
                else begin
                    state_s = RUN;
                end
            end
            DRAIN: state_s = EMIT;
            EMIT: begin
                if (out_ready && out_last_r) begin
                    state_s = IDLE;
                end else if (out_ready) begin
                    state_s = READ;
                end else begin
                    state_s = EMIT;
                end
            end
`ifdef MIN_SCHED_TIMEOUT_EN
            ERR:   state_s = ERR;
`endif
            default: state_s = IDLE;
        endcase
    end

    // State register and control outputs, registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            mem_rd_en_r <= 1'b0;
            fm_start_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= (state_s == IDLE);
            mem_rd_en_r <= (state_s == READ);
            fm_start_r  <= (state_s == RUN);
            out_valid_r <= (state_s == EMIT);
            out_last_r  <= (state_s == EMIT) && last_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    // Job bookkeeping: capture base/count on accept, advance row on a non-final handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_addr_r <= {ADDR_W{1'b0}};
            idx_r      <= {(ADDR_W+1){1'b0}};
            cnt_r      <= {(ADDR_W+1){1'b0}};
        end else if ((state_r == IDLE) && cmd_valid && rows_nz_s) begin
            row_addr_r <= cmd_base;
            idx_r      <= {(ADDR_W+1){1'b0}};
            cnt_r      <= cmd_rows;
        end else if ((state_r == EMIT) && out_ready && !out_last_r) begin
            row_addr_r <= row_addr_r + ADDR_ONE;
            idx_r      <= idx_r + CNT_ONE;
        end else begin
            row_addr_r <= row_addr_r;
            idx_r      <= idx_r;
            cnt_r      <= cnt_r;
        end
    end

    // Data path: latch the read row in LOAD and the minimum when the unit reports done.
    always_ff @(posedge clk) begin
        if (rst) begin
            fm_numbers_r <= {(LANES*DW){1'b0}};
            out_data_r   <= {DW{1'b0}};
        end else begin
            if (state_r == LOAD) begin
                fm_numbers_r <= mem_rd_data;
            end
            if ((state_r == RUN) && fm_done) begin
                out_data_r <= fm_result;
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign mem_rd_en   = mem_rd_en_r;
    assign mem_rd_addr = row_addr_r;
    assign fm_numbers  = fm_numbers_r;
    assign fm_start    = fm_start_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_row     = row_addr_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_min_row_sched.sv
// Self-checking bench for min_row_sched with a row memory model, a
// behavioural min unit and a queue of expected per-row results.
// Define MIN_SCHED_TIMEOUT_EN to also exercise the watchdog/ERR path.
`timescale 1ns/1ps
module tb_min_row_sched;

    localparam int LANES  = 8;
    localparam int DW     = 16;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [DW-1:0]     data;
        logic              last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_base = '0;
    logic [ADDR_W:0]       cmd_rows = '0;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic [LANES*DW-1:0]   mem_rd_data = '0;
    logic [LANES*DW-1:0]   fm_numbers;
    logic                  fm_start;
    logic                  fm_done = 1'b0;
    logic [DW-1:0]         fm_result = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DW-1:0]         out_data;
    logic [ADDR_W-1:0]     out_row;
    logic                  out_last;
    logic                  busy;

    logic [LANES*DW-1:0]   mem [0:255];
    exp_t                  exp_q[$];
    logic [ADDR_W-1:0]     rd_addr_q[$];
    int                    checks = 0;
    int                    errors = 0;
    int                    cyc = 0;
    int                    rd_cnt = 0;
    int                    ov_cnt = 0;
    int                    unstable = 0;
    int                    fm_cnt = 0;
    int                    fm_lat = 2;
    bit                    stuck = 1'b0;
    logic                  fm_start_d = 1'b0;
    logic [LANES*DW-1:0]   fm_num_d = '0;

    min_row_sched #(.LANES(LANES), .DW(DW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_rows(cmd_rows),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .fm_numbers(fm_numbers), .fm_start(fm_start), .fm_done(fm_done), .fm_result(fm_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lane_min(input logic [LANES*DW-1:0] v);
        logic [DW-1:0] m;
        m = v[DW-1:0];
        for (int i = 1; i < LANES; i++) begin
            if (v[i*DW +: DW] < m) m = v[i*DW +: DW];
        end
        return m;
    endfunction

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Row memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Behavioural min unit: done pulses fm_lat+1 cycles after fm_start rises.
    always @(posedge clk) begin
        if (!fm_start || stuck) begin
            fm_cnt  <= 0;
            fm_done <= 1'b0;
        end else begin
            if (fm_cnt == fm_lat) begin
                fm_done   <= 1'b1;
                fm_result <= lane_min(fm_numbers);
            end else begin
                fm_done <= 1'b0;
            end
            if (fm_cnt < 1000) fm_cnt <= fm_cnt + 1;
        end
    end

    // Bus monitor: read log, valid-cycle count and fm_numbers stability while fm_start is held.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            rd_addr_q.push_back(mem_rd_addr);
        end
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (fm_start && fm_start_d && (fm_numbers !== fm_num_d)) unstable <= unstable + 1;
        fm_start_d <= fm_start;
        fm_num_d   <= fm_numbers;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "time limit");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_rows(input logic [ADDR_W-1:0] base, input int rows);
        logic [LANES*DW-1:0] row;
        logic [DW-1:0]       m;
        int                  k;
        exp_t                e;
        for (int r = 0; r < rows; r++) begin
            m = DW'($urandom_range(0, 255));
            k = $urandom_range(0, LANES - 1);
            for (int i = 0; i < LANES; i++) begin
                row[i*DW +: DW] = (i == k) ? m : DW'($urandom_range(256, 65535));
            end
            mem[ADDR_W'(base + ADDR_W'(r))] = row;
            e.row  = ADDR_W'(base + ADDR_W'(r));
            e.data = m;
            e.last = (r == rows - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] base, input int rows);
        cmd_base  = base;
        cmd_rows  = (ADDR_W+1)'(rows);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (fm_start) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({cmd_ready, mem_rd_en, fm_start, out_valid, out_last, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/rd/st/ov/last/busy=%b, want 100000",
                     {cmd_ready, mem_rd_en, fm_start, out_valid, out_last, busy});
        end
        checks++;
        if (fm_numbers !== '0 || out_data !== '0 || mem_rd_addr !== '0 || out_row !== '0) begin
            errors++;
            $display("FAIL reset_data: fm_numbers=%h out_data=%h addr=%h row=%h, want all 0",
                     fm_numbers, out_data, mem_rd_addr, out_row);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_rows8();
        bit   ok;
        exp_t e;
        int   t0;
        logic [ADDR_W-1:0] a;
        exp_q.delete();
        rd_addr_q.delete();
        out_ready = 1'b1;
        fill_rows(8'h00, 8);
        issue(8'h00, 8);
        t0 = cyc;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rows8_accept: busy=%b cmd_ready=%b, want 1/0", busy, cmd_ready);
        end
        for (int r = 0; r < 8; r++) begin
            wait_valid(300, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rows8_valid_timeout: row %0d never valid, want valid", r);
                return;
            end
            if (r == 0) begin
                checks++;
                if (cyc - t0 !== 4 + fm_lat + 1) begin
                    errors++;
                    $display("FAIL rows8_latency: got %0d cycles, want %0d", cyc - t0, 4 + fm_lat + 1);
                end
            end
            e = exp_q.pop_front();
            checks++;
            if ({out_row, out_data, out_last} !== {e.row, e.data, e.last}) begin
                errors++;
                $display("FAIL rows8_result: row/data/last=%h/%h/%b, want %h/%h/%b",
                         out_row, out_data, out_last, e.row, e.data, e.last);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rows8_done: busy=%b cmd_ready=%b out_valid=%b, want 0/1/0",
                     busy, cmd_ready, out_valid);
        end
        checks++;
        if (rd_addr_q.size() !== 8) begin
            errors++;
            $display("FAIL rows8_reads: got %0d reads, want 8", rd_addr_q.size());
        end else begin
            for (int r = 0; r < 8; r++) begin
                a = rd_addr_q[r];
                checks++;
                if (a !== ADDR_W'(r)) begin
                    errors++;
                    $display("FAIL rows8_addr: read %0d addr %h, want %h", r, a, ADDR_W'(r));
                end
            end
        end
    endtask

    task automatic test_rows_zero();
        int rd0;
        int ov0;
        rd0 = rd_cnt;
        ov0 = ov_cnt;
        issue(8'h05, 0);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
        end
        repeat (10) step();
        checks++;
        if (rd_cnt !== rd0 || ov_cnt !== ov0) begin
            errors++;
            $display("FAIL zero_activity: reads %0d valids %0d, want 0/0", rd_cnt - rd0, ov_cnt - ov0);
        end
    endtask

    task automatic test_wrap();
        bit   ok;
        exp_t e;
        logic [ADDR_W-1:0] want [3];
        logic [ADDR_W-1:0] a;
        want[0] = 8'hFE;
        want[1] = 8'hFF;
        want[2] = 8'h00;
        exp_q.delete();
        rd_addr_q.delete();
        fill_rows(8'hFE, 3);
        issue(8'hFE, 3);
        for (int r = 0; r < 3; r++) begin
            wait_valid(300, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_valid_timeout: row %0d never valid, want valid", r);
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if ({out_row, out_data, out_last} !== {e.row, e.data, e.last}) begin
                errors++;
                $display("FAIL wrap_result: row/data/last=%h/%h/%b, want %h/%h/%b",
                         out_row, out_data, out_last, e.row, e.data, e.last);
            end
            step();
        end
        checks++;
        if (rd_addr_q.size() !== 3) begin
            errors++;
            $display("FAIL wrap_reads: got %0d reads, want 3", rd_addr_q.size());
        end else begin
            for (int r = 0; r < 3; r++) begin
                a = rd_addr_q[r];
                checks++;
                if (a !== want[r]) begin
                    errors++;
                    $display("FAIL wrap_addr: read %0d addr %h, want %h", r, a, want[r]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        exp_t e;
        int   rd0;
        int   bad;
        logic [DW-1:0]     d;
        logic [ADDR_W-1:0] rw;
        exp_q.delete();
        fill_rows(8'h20, 4);
        out_ready = 1'b0;
        issue(8'h20, 4);
        for (int r = 0; r < 4; r++) begin
            wait_valid(300, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bp_valid_timeout: row %0d never valid, want valid", r);
                out_ready = 1'b1;
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if ({out_row, out_data, out_last} !== {e.row, e.data, e.last}) begin
                errors++;
                $display("FAIL bp_result: row/data/last=%h/%h/%b, want %h/%h/%b",
                         out_row, out_data, out_last, e.row, e.data, e.last);
            end
            if (r == 2) begin
                d   = out_data;
                rw  = out_row;
                rd0 = rd_cnt;
                bad = 0;
                repeat (10) begin
                    step();
                    if (out_valid !== 1'b1 || out_data !== d || out_row !== rw) bad++;
                end
                checks++;
                if (bad !== 0) begin
                    errors++;
                    $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
                end
                checks++;
                if (rd_cnt !== rd0) begin
                    errors++;
                    $display("FAIL bp_prefetch: %0d reads while blocked, want 0", rd_cnt - rd0);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        bit   ok;
        exp_t e;
        exp_q.delete();
        stuck = 1'b1;
        fill_rows(8'h40, 2);
        issue(8'h40, 2);
        wait_start(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_start: fm_start never rose, want 1");
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++;
        if ({fm_start, busy, cmd_ready, out_valid, mem_rd_en} !== 5'b00100) begin
            errors++;
            $display("FAIL midrst_idle: st/busy/rdy/ov/rd=%b, want 00100",
                     {fm_start, busy, cmd_ready, out_valid, mem_rd_en});
        end
        rst   = 1'b0;
        stuck = 1'b0;
        step();
        exp_q.delete();
        fill_rows(8'h50, 2);
        issue(8'h50, 2);
        for (int r = 0; r < 2; r++) begin
            wait_valid(300, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL midrst_valid_timeout: row %0d never valid, want valid", r);
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if ({out_row, out_data, out_last} !== {e.row, e.data, e.last}) begin
                errors++;
                $display("FAIL midrst_result: row/data/last=%h/%h/%b, want %h/%h/%b",
                         out_row, out_data, out_last, e.row, e.data, e.last);
            end
            step();
        end
    endtask

`ifdef MIN_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int run;
        int rd0;
        exp_q.delete();
        stuck = 1'b1;
        fill_rows(8'h60, 1);
        issue(8'h60, 1);
        wait_start(50, ok);
        run = 0;
        while (fm_start && run < 400) begin
            run++;
            step();
        end
        checks++;
        if (run !== 256) begin
            errors++;
            $display("FAIL timeout_cycles: RUN lasted %0d cycles, want 256", run);
        end
        repeat (5) step();
        checks++;
        if ({fm_start, busy, cmd_ready, out_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_err: st/busy/rdy/ov=%b, want 0100",
                     {fm_start, busy, cmd_ready, out_valid});
        end
        rd0 = rd_cnt;
        issue(8'h00, 1);
        repeat (5) step();
        checks++;
        if (rd_cnt !== rd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: reads %0d busy=%b, want 0/1", rd_cnt - rd0, busy);
        end
        rst = 1'b1;
        step();
        rst   = 1'b0;
        stuck = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rst: busy=%b cmd_ready=%b, want 0/1", busy, cmd_ready);
        end
        step();
    endtask
`endif

    task automatic test_stability();
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL fm_numbers_stable: %0d changes during fm_start, want 0", unstable);
        end
    endtask

    initial begin
        test_reset();
        test_rows8();
        test_rows_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid_run();
`ifdef MIN_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_stability();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
